core_boot_sequencer: RTL and testbench
======================================

Name: core_boot_sequencer

Overview:
- Sequences start-up of the pipelined RISC-V core.
- Holds the core in reset while it receives a program image as a UART byte stream, assembles it into 32-bit words and writes them into instruction memory.
- Releases the core, then watches the core status word for halt.
- Sits between the UART receiver, the instruction-memory write port and the core's reset input.

Parameters:
- ADDR_W, 14, instruction-memory word-address width; capacity = 2^ADDR_W words.
- HALT_BIT, 0, bit index of core_status that signals core halt.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- rx_valid  input  1  one-cycle strobe: rx_data holds a received byte
- rx_data  input  8  received byte
- core_status  input  32  status word from core
- imem_we  output  1  instruction-memory write enable (one-cycle pulse)
- imem_addr  output  ADDR_W  word address for the write
- imem_wdata  output  32  word to write
- core_rst  output  1  active-high reset to core
- load_done  output  1  one-cycle pulse when the image is fully written
- running  output  1  high while the core is released and not halted
- halted  output  1  sticky; core reported halt
- err  output  1  sticky; declared length exceeds capacity

Behaviour:
- Reset (async, rst=1):
  - State is S_LEN; byte index = 0; word counter = 0; length = 0.
  - core_rst=1, imem_we=0, imem_addr=0, imem_wdata=0, load_done=0, running=0, halted=0, err=0.
- Byte assembly:
  - Bytes are little-endian: byte k of a word goes to bits [8k+7:8k].
  - The 2-bit byte index increments on each rx_valid and wraps 3->0.
  - rx_valid is ignored in S_RUN, S_HALT and S_ERR.
- S_LEN: the first 4 bytes form the 32-bit word count N.
  - On the 4th byte, at the next clock edge:
    - N=0 -> S_RUN; load_done pulses in that same cycle.
    - N > 2^ADDR_W -> S_ERR; err=1.
    - Otherwise -> S_LOAD.
- S_LOAD: each completed word is written to memory.
  - In the cycle after the 4th byte's rx_valid:
    - imem_we=1 for exactly one cycle.
    - imem_wdata = the assembled word.
    - imem_addr = current word counter. The counter starts at 0 and increments after each write.
  - Writes are registered, so addr and data are stable in the same cycle as imem_we.
  - When the write of word N-1 is issued:
    - load_done pulses in the following cycle.
    - The state moves to S_RUN in that same following cycle.
  - Back-to-back rx_valid on consecutive cycles must be accepted with no byte lost.
  - A write pulse and the next byte's capture may coincide.
- S_RUN:
  - core_rst=0 from the first cycle in S_RUN; running=1.
  - When core_status[HALT_BIT]=1 is sampled -> S_HALT on the next edge.
- S_HALT:
  - core_rst stays 0, so the core may keep driving I/O.
  - running=0, halted=1.
  - Terminal until rst.
- S_ERR:
  - core_rst=1, err=1.
  - No memory writes; terminal until rst.
- Width rules:
  - The word counter is ADDR_W+1 bits wide, so a count of exactly 2^ADDR_W is representable.
  - imem_addr is its low ADDR_W bits.
  - N is compared as an unsigned 32-bit value.
- Reset mid-load: all state returns to reset values and core_rst reasserts in the same cycle (asynchronous). Partially written memory is not cleared.
- Reset mid-run: core_rst reasserts immediately; a new image is expected.
- A halt bit already set when entering S_RUN is honoured: S_HALT is entered after one cycle in S_RUN.

Decomposition:
- Shared package holds:
  - state encoding (S_LEN, S_LOAD, S_RUN, S_HALT, S_ERR as a 3-bit enum);
  - BYTES_PER_WORD = 4;
  - the default HALT_BIT.
- One natural sub-module, byte_word_assembler:
  - accepts rx_valid/rx_data;
  - keeps the byte index and shift register;
  - emits word_valid (pulse) and word (32 bits);
  - has a clear input driven by the FSM on state entry.

Test Plan:
- Length bytes 02 00 00 00, then 78 56 34 12 EF BE AD DE -> two imem_we pulses:
  - addr 0, data 0x12345678;
  - addr 1, data 0xDEADBEEF.
  - load_done pulses once, then core_rst falls and running=1.
- Length bytes 00 00 00 00 -> no imem_we; load_done pulses; core_rst=0 in the following cycle.
- Length 0x00004001 with ADDR_W=14 -> err=1, core_rst stays 1, and further bytes produce no imem_we.
- 12 bytes sent on consecutive cycles with N=3 -> exactly 3 writes, at addrs 0, 1, 2, with correct data and no dropped bytes.
- In S_RUN, drive core_status=0x00000001 -> halted=1 and running=0 next cycle; core_rst remains 0.
- Assert rst after 5 of 8 payload bytes -> core_rst=1 and all outputs at reset values immediately; resending the full image then loads correctly from addr 0.

Source files
------------

// File: rtl/core_boot_sequencer_pkg.sv
// rtl/core_boot_sequencer_pkg.sv - shared constants for the core boot sequencer
// Purpose: FSM state encoding, word geometry and default halt-bit index.
// Ports: none (package).
package core_boot_sequencer_pkg;

  localparam int BYTES_PER_WORD   = 4;
  localparam int HALT_BIT_DEFAULT = 0;

  typedef logic [2:0] state_t;

  localparam state_t S_LEN  = 3'd0;
  localparam state_t S_LOAD = 3'd1;
  localparam state_t S_RUN  = 3'd2;
  localparam state_t S_HALT = 3'd3;
  localparam state_t S_ERR  = 3'd4;

endpackage

// File: rtl/core_boot_sequencer_byte_word_assembler.sv
// rtl/core_boot_sequencer_byte_word_assembler.sv - little-endian byte-to-word assembler
// Purpose: collects received bytes into 32-bit words, byte k into bits [8k+7:8k].
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_en            accept bytes only while high
//   i_clr           return byte index and partial word to zero
//   i_rx_valid      byte strobe
//   i_rx_data       received byte
//   o_word_valid    pulse in the cycle the fourth byte of a word is presented
//   o_word          assembled word, valid with o_word_valid
module core_boot_sequencer_byte_word_assembler
  import core_boot_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic        i_clr,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_idx;
  logic [23:0] r_shift;
  logic        w_take;

  assign w_take = i_en & i_rx_valid;

  // The final byte is merged combinationally so the consumer can register the
  // complete word on the same edge that accepts the byte; no extra latency.
  assign o_word_valid = w_take && (r_idx == 2'(BYTES_PER_WORD - 1));
  assign o_word       = {i_rx_data, r_shift};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= 2'd0;
      r_shift <= 24'd0;
    end else if (i_clr) begin
      r_idx   <= 2'd0;
      r_shift <= 24'd0;
    end else if (w_take) begin
      r_idx <= r_idx + 2'd1;
      case (r_idx)
        2'd0:    r_shift[7:0]   <= i_rx_data;
        2'd1:    r_shift[15:8]  <= i_rx_data;
        2'd2:    r_shift[23:16] <= i_rx_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/core_boot_sequencer.sv
// rtl/core_boot_sequencer.sv - loads a UART program image into imem, then releases the core
// Purpose: holds the core in reset while a length-prefixed image is written to
// instruction memory, releases it, and watches the status word for halt.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   rx_valid, rx_data     received byte stream
//   core_status           status word from the core (halt at HALT_BIT)
//   imem_we/addr/wdata    registered instruction-memory write port
//   core_rst              active-high reset to the core
//   load_done             pulse when the image is complete
//   running, halted, err  status flags
module core_boot_sequencer
  import core_boot_sequencer_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int HALT_BIT = HALT_BIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic [31:0]       core_status,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              running,
  output logic              halted,
  output logic              err
);

  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

  state_t            r_state;
  logic [31:0]       r_len;
  logic [ADDR_W:0]   r_cnt;
  logic              r_last;

  logic              w_en;
  logic              w_clr;
  logic              w_word_valid;
  logic [31:0]       w_word;
  logic [ADDR_W:0]   w_cnt_next;
  logic              w_is_last;
  logic              w_unused;

  // Bytes arriving after the final word has been issued are not part of the image.
  assign w_en  = (r_state == S_LEN) || ((r_state == S_LOAD) && !r_last);
  assign w_clr = ((r_state == S_LEN) && w_word_valid) || ((r_state == S_LOAD) && r_last);

  assign w_cnt_next = r_cnt + 1'b1;
  assign w_is_last  = ({{(31 - ADDR_W){1'b0}}, w_cnt_next} == r_len);

  assign w_unused = &{1'b0, core_status};

  core_boot_sequencer_byte_word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .i_en         (w_en),
    .i_clr        (w_clr),
    .i_rx_valid   (rx_valid),
    .i_rx_data    (rx_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_LEN;
      r_len      <= 32'd0;
      r_cnt      <= '0;
      r_last     <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      load_done  <= 1'b0;
    end else begin
      imem_we   <= 1'b0;
      load_done <= 1'b0;
      case (r_state)
        S_LEN: begin
          if (w_word_valid) begin
            r_len <= w_word;
            if (w_word == 32'd0) begin
              r_state   <= S_RUN;
              load_done <= 1'b1;
            end else if (w_word > CAPACITY) begin
              r_state <= S_ERR;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          // r_last marks that the final write is on the bus this cycle.
          if (r_last) begin
            r_state   <= S_RUN;
            load_done <= 1'b1;
          end else if (w_word_valid) begin
            imem_we    <= 1'b1;
            imem_addr  <= r_cnt[ADDR_W-1:0];
            imem_wdata <= w_word;
            r_cnt      <= w_cnt_next;
            r_last     <= w_is_last;
          end
        end
        S_RUN: begin
          if (core_status[HALT_BIT]) r_state <= S_HALT;
        end
        default: ;
      endcase
    end
  end

  // Decoded from the state register so an asynchronous reset reasserts core_rst at once.
  assign core_rst = (r_state == S_LEN) || (r_state == S_LOAD) || (r_state == S_ERR);
  assign running  = (r_state == S_RUN);
  assign halted   = (r_state == S_HALT);
  assign err      = (r_state == S_ERR);

endmodule

// File: tb/tb_core_boot_sequencer.sv
// tb/tb_core_boot_sequencer.sv - self-checking bench for core_boot_sequencer
module tb_core_boot_sequencer;

  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic [31:0]       core_status;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              load_done;
  logic              running;
  logic              halted;
  logic              err;

  core_boot_sequencer #(.ADDR_W(ADDR_W), .HALT_BIT(0)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .core_status(core_status), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_rst(core_rst), .load_done(load_done),
    .running(running), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Image-level model: phase 0 receiving, 1 running, 2 halted, 3 length error.
  int          m_phase = 0;
  int          m_nb = 0;
  logic [31:0] m_acc = 0;
  logic [31:0] m_len = 0;
  bit          m_done_pend = 0;
  logic        e_we = 0;
  logic [31:0] e_addr = 0;
  logic [31:0] e_wdata = 0;
  logic        e_done = 0;

  int          wlog_addr[$];
  logic [31:0] wlog_data[$];
  int          done_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_nb = 0; m_acc = 0; m_len = 0; m_done_pend = 0;
      e_we = 0; e_addr = 0; e_wdata = 0; e_done = 0;
    end else begin
      e_we = 0;
      e_done = 0;
      if (m_phase == 0) begin
        if (m_done_pend) begin
          m_phase = 1;
          e_done = 1;
        end else if (rx_valid) begin
          m_acc = {rx_data, m_acc[31:8]};
          m_nb++;
          if (m_nb == 4) begin
            m_len = m_acc;
            if (m_len == 0) begin
              m_phase = 1;
              e_done = 1;
            end else if (m_len > (32'd1 << ADDR_W)) begin
              m_phase = 3;
            end
          end else if (m_nb % 4 == 0) begin
            int j;
            j = m_nb / 4 - 2;
            e_we = 1;
            e_addr = j;
            e_wdata = m_acc;
            if (j == int'(m_len) - 1) m_done_pend = 1;
          end
        end
      end else if (m_phase == 1) begin
        if (core_status[0]) m_phase = 2;
      end
    end
    #1;
    chk("imem_we", imem_we, e_we);
    chk("imem_addr", imem_addr, e_addr[ADDR_W-1:0]);
    chk("imem_wdata", imem_wdata, e_wdata);
    chk("load_done", load_done, e_done);
    chk("core_rst", core_rst, (m_phase == 0 || m_phase == 3));
    chk("running", running, (m_phase == 1));
    chk("halted", halted, (m_phase == 2));
    chk("err", err, (m_phase == 3));
    if (imem_we === 1'b1) begin
      wlog_addr.push_back(int'(imem_addr));
      wlog_data.push_back(imem_wdata);
    end
    if (load_done === 1'b1) done_cnt++;
  end

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic clear_logs();
    wlog_addr.delete();
    wlog_data.delete();
    done_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
  endtask

  logic [7:0] img1[12] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                           8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [7:0] img_err[12] = '{8'h01, 8'h40, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                              8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] img3[16] = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                           8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    core_status = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_core_rst", core_rst, 1);
    chk("reset_imem_we", imem_we, 0);
    chk("reset_running", running, 0);
    chk("reset_err", err, 0);
    rst = 1'b0;
    clear_logs();

    // two-word image, bytes spaced
    for (int i = 0; i < 12; i++) begin push(img1[i]); idle(1); end
    idle(4);
    chk("t1_nwrites", wlog_addr.size(), 2);
    if (wlog_addr.size() == 2) begin
      chk("t1_addr0", wlog_addr[0], 0);
      chk("t1_data0", wlog_data[0], 32'h12345678);
      chk("t1_addr1", wlog_addr[1], 1);
      chk("t1_data1", wlog_data[1], 32'hDEADBEEF);
    end
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_running", running, 1);
    chk("t1_core_rst", core_rst, 0);

    // halt while running
    @(negedge clk);
    core_status = 32'h0000_0001;
    idle(2);
    chk("t2_halted", halted, 1);
    chk("t2_running", running, 0);
    chk("t2_core_rst", core_rst, 0);
    core_status = 32'h0;

    // empty image
    do_reset();
    for (int i = 0; i < 4; i++) begin push(8'h00); idle(1); end
    idle(2);
    chk("t3_nwrites", wlog_addr.size(), 0);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_core_rst", core_rst, 0);
    chk("t3_running", running, 1);

    // length 0x4001 exceeds capacity
    do_reset();
    for (int i = 0; i < 12; i++) begin push(img_err[i]); idle(1); end
    idle(3);
    chk("t4_err", err, 1);
    chk("t4_core_rst", core_rst, 1);
    chk("t4_nwrites", wlog_addr.size(), 0);
    chk("t4_done_cnt", done_cnt, 0);

    // three words back-to-back
    do_reset();
    for (int i = 0; i < 16; i++) push(img3[i]);
    idle(4);
    chk("t5_nwrites", wlog_addr.size(), 3);
    if (wlog_addr.size() == 3) begin
      chk("t5_addr0", wlog_addr[0], 0);
      chk("t5_data0", wlog_data[0], 32'h44332211);
      chk("t5_addr1", wlog_addr[1], 1);
      chk("t5_data1", wlog_data[1], 32'h88776655);
      chk("t5_addr2", wlog_addr[2], 2);
      chk("t5_data2", wlog_data[2], 32'hCCBBAA99);
    end
    chk("t5_done_cnt", done_cnt, 1);

    // reset after 5 payload bytes, then reload with halt already requested
    do_reset();
    for (int i = 0; i < 9; i++) begin push(img1[i]); idle(1); end
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_core_rst", core_rst, 1);
    chk("t6_imem_we", imem_we, 0);
    chk("t6_imem_addr", imem_addr, 0);
    chk("t6_imem_wdata", imem_wdata, 0);
    chk("t6_load_done", load_done, 0);
    chk("t6_running", running, 0);
    chk("t6_halted", halted, 0);
    chk("t6_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    core_status = 32'h0000_0001;
    for (int i = 0; i < 12; i++) begin push(img1[i]); idle(1); end
    idle(4);
    chk("t6_nwrites", wlog_addr.size(), 2);
    if (wlog_addr.size() == 2) begin
      chk("t6_addr0", wlog_addr[0], 0);
      chk("t6_data0", wlog_data[0], 32'h12345678);
      chk("t6_data1", wlog_data[1], 32'hDEADBEEF);
    end
    chk("t6_halted_end", halted, 1);
    chk("t6_core_rst_end", core_rst, 0);
    core_status = 32'h0;

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
